// File: rtl/mul_seq_32_if.sv
// Request/response and external-adder signals for the sequential multiplier.
// Master is the requester and adder side; slave is the multiplier.
interface mul_seq_32_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_cin;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b, add_s, add_cout,
    input  add_x, add_y, add_cin, busy, done, product
  );

  modport slave (
    input  start, a, b, add_s, add_cout,
    output add_x, add_y, add_cin, busy, done, product
  );
endinterface

// File: rtl/mul_seq_32.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier driving an external ripple adder.
// One add per clock: start edge + WIDTH CALC edges, then a one-cycle done pulse.
module mul_seq_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  mul_seq_32_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  // The adder operands come straight from registers so the adder sees a full cycle.
  assign bus.add_x   = acc_hi;
  assign bus.add_y   = acc_lo[0] ? mcand : '0;
  assign bus.add_cin = 1'b0;

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.start) begin
            mcand  <= bus.a;
            acc_lo <= bus.b;
            acc_hi <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          // add_cout becomes the new MSB; the consumed multiplier bit falls off the bottom.
          {acc_hi, acc_lo} <= {bus.add_cout, bus.add_s, acc_lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= {bus.add_cout, bus.add_s, acc_lo[WIDTH-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_32.sv
// Directed and random checks of mul_seq_32 with a behavioural 32-bit adder in the loop.
module tb_mul_seq_32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mul_seq_32_if #(.WIDTH(32)) bus ();

  mul_seq_32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ripple adder stand-in: x + y + cin.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {32'd0, bus.add_cin};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then watch 40 edges. lat = edges after the start edge until done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int lat, output int busy_cnt,
                        output int done_cnt, output int ybad, output int cinbad);
    prod = '0; lat = -1; busy_cnt = 0; done_cnt = 0; ybad = 0; cinbad = 0;
    bus.start = 1'b1; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.add_y !== 32'd0) ybad++;
      if (bus.add_cin !== 1'b0) cinbad++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat  = k;
          prod = bus.product;
        end
      end
    end
  endtask

  initial begin
    logic [63:0] prod;
    int lat, bc, dc, yb, cb;
    logic [31:0] ra, rb, a1, b1, a2, b2;

    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h1234_5678, 32'd0,         64'h0};
    vecs[3] = '{32'd0,         32'hFFFF_FFFF, 64'h0};
    vecs[4] = '{32'd1,         32'h8000_0000, 64'h0000_0000_8000_0000};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[8] = '{32'hDEAD_BEEF, 32'd2,         64'h0000_0001_BD5B_7DDE};
    vecs[9] = '{32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780};

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #2;
    chk("reset_busy",    64'(bus.busy),    64'd0);
    chk("reset_done",    64'(bus.done),    64'd0);
    chk("reset_product", bus.product,      64'd0);
    chk("reset_add_x",   64'(bus.add_x),   64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, prod, lat, bc, dc, yb, cb);
      chk($sformatf("vec%0d_product", i), prod, vecs[i].exp);
      chk($sformatf("vec%0d_done_cycle", i), 64'(lat + 1), 64'd33);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd32);
      chk($sformatf("vec%0d_done_pulses", i), 64'(dc), 64'd1);
      chk($sformatf("vec%0d_cin", i), 64'(cb), 64'd0);
      if (vecs[i].b == 32'd0) chk($sformatf("vec%0d_add_y_zero", i), 64'(yb), 64'd0);
      chk($sformatf("vec%0d_product_held", i), bus.product, vecs[i].exp);
    end

    // Start held high, operands changing during CALC; second op chains from DONE.
    a1 = 32'h0000_BEEF; b1 = 32'h0000_1234; a2 = 32'h0000_0007; b2 = 32'h0000_0006;
    bus.start = 1'b1; bus.a = a1; bus.b = b1;
    @(posedge clk); #1;
    dc = 0; lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      if (bus.done) begin
        dc++;
        lat = k;
      end
    end
    chk("b2b_first_done_cycle", 64'(lat + 1), 64'd33);
    chk("b2b_first_product", bus.product, 64'(a1) * 64'(b1));
    bus.a = a2; bus.b = b2;
    @(posedge clk); #1;
    chk("b2b_rechain_busy", 64'(bus.busy), 64'd1);
    chk("b2b_rechain_done_low", 64'(bus.done), 64'd0);
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 10) chk("b2b_product_held_in_calc", bus.product, 64'(a1) * 64'(b1));
      if (bus.done) begin
        dc++;
        if (lat < 0) begin
          lat = k;
          prod = bus.product;
        end
      end
    end
    chk("b2b_second_done_cycle", 64'(lat + 1), 64'd33);
    chk("b2b_second_product", prod, 64'd42);
    chk("b2b_done_pulses", 64'(dc), 64'd2);

    // Asynchronous reset mid-CALC.
    bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",    64'(bus.busy), 64'd0);
    chk("arst_done",    64'(bus.done), 64'd0);
    chk("arst_product", bus.product,   64'd0);
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      if (bus.done) dc++;
    end
    chk("arst_no_done", 64'(dc), 64'd0);
    @(negedge clk);
    run_op(32'd7, 32'd9, prod, lat, bc, dc, yb, cb);
    chk("arst_fresh_product", prod, 64'd63);
    chk("arst_fresh_done_cycle", 64'(lat + 1), 64'd33);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom;
      run_op(ra, rb, prod, lat, bc, dc, yb, cb);
      chk($sformatf("rand%0d_product a=%0h b=%0h", i, ra, rb), prod, 64'(ra) * 64'(rb));
      chk($sformatf("rand%0d_done_cycle", i), 64'(lat + 1), 64'd33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
- Sequential unsigned 32x32->64 shift-and-add multiplier.
- Sits directly upstream of the team's 32-bit ripple full adder. Each iteration it drives the adder operands and carry-in, then captures the adder's sum and carry-out.
- The adder is instantiated outside this block, next to it in the datapath. This block contains no adder of its own.

Parameters:
- WIDTH, 32, operand width. Must equal the adder width.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a multiply. Sampled on the rising edge.
- a  in  WIDTH  multiplicand. Captured on an accepted start.
- b  in  WIDTH  multiplier. Captured on an accepted start.
- add_x  out  WIDTH  adder operand x = acc_hi register.
- add_y  out  WIDTH  adder operand y = mcand when acc_lo[0]=1, else 0.
- add_cin  out  1  adder carry-in. Constant 0.
- add_s  in  WIDTH  adder sum. Combinational return from the adder.
- add_cout  in  1  adder carry-out.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse when product is valid.
- product  out  2*WIDTH  result {acc_hi, acc_lo}. Held until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - acc_hi=0, acc_lo=0, mcand=0, cnt=0.
  - Any operation in progress is abandoned with no done pulse.
- States:
  - IDLE: waiting for start.
  - CALC: WIDTH iterations.
  - DONE: single cycle, done=1.
- Start acceptance:
  - start=1 is accepted in IDLE or DONE.
  - On acceptance: mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=0, state<=CALC.
  - start=1 in CALC is ignored; the operands are not recaptured.
- CALC, each edge:
  - {acc_hi, acc_lo} <= {add_cout, add_s, acc_lo[WIDTH-1:1]}. This is a 65-bit right shift that drops acc_lo[0].
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, state<=DONE instead of continuing.
- Adder contract:
  - The adder path is combinational and must settle within one clock.
  - add_cin is held at 0 at all times.
  - In IDLE and DONE, add_x and add_y still follow the registers; the returned values are ignored.
- Latency:
  - Start accepted at edge T0.
  - CALC edges are T1..T32.
  - done=1 and product valid during the cycle after T32.
  - Total: 33 cycles from the start edge to done visible. busy=1 exactly 32 cycles.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge goes to IDLE, or to CALC if start=1 (back-to-back; done still pulses only once).
- Width rules:
  - The product is exact. Overflow cannot occur.
  - add_cout is the only carry source into bit 2*WIDTH-1 of the shift.
- product port:
  - Mirrors {acc_hi, acc_lo} only while in DONE.
  - Holds its last value in IDLE and CALC. Compliant implementations use a separate product register loaded on the DONE entry edge.

Test Plan:
- a=3, b=5, start pulsed one cycle -> busy high 32 cycles; done pulses at cycle 33; product=0x0000_0000_0000_000F.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001. Confirms add_cout propagates into acc_hi[31] on each iteration.
- a=0x1234_5678, b=0 -> product=0. add_y stays 0 throughout CALC, and add_cin is 0 on every cycle.
- Start held high continuously with changing a/b during CALC -> only the first operands are used. After the first done, a second operation starts immediately from the DONE state; exactly one done pulse per operation.
- rst_n driven low asynchronously at cycle 10 of CALC -> busy, done and product go to 0 immediately with no clock edge, and no done pulse follows. A fresh start after release yields the correct product.
- Random 200 operand pairs checked against a 64-bit reference product -> product matches exactly and done latency is always 33 cycles.
